execute: RTL and testbench



---
 rtl/rv32_pkg.sv | 37 +++
 rtl/alu.sv | 27 ++
 rtl/execute.sv | 122 ++++++++++++
 tb/tb_execute.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions used by decode and execute: opcodes, funct3 codes,
// SYSTEM encodings that halt the core, and the execute halt FSM state type.
package rv32_pkg;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BCC   = 7'b1100011;
  localparam logic [6:0] LCC   = 7'b0000011;
  localparam logic [6:0] SCC   = 7'b0100011;
  localparam logic [6:0] MCC   = 7'b0010011;
  localparam logic [6:0] RCC   = 7'b0110011;
  localparam logic [6:0] SYS   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {RUN, HALT} halt_state_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; alt_i selects SUB for ADD and SRA for SRL.
module alu
  import rv32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  output logic [31:0] res_o
);

  always_comb begin
    res_o = 32'h0;
    unique case (funct3_i)
      F3_ADD:  res_o = alt_i ? a_i - b_i : a_i + b_i;
      F3_SLL:  res_o = a_i << b_i[4:0];
      F3_SLT:  res_o = {31'h0, $signed(a_i) < $signed(b_i)};
      F3_SLTU: res_o = {31'h0, a_i < b_i};
      F3_XOR:  res_o = a_i ^ b_i;
      F3_SR:   res_o = alt_i ? 32'($signed(a_i) >>> b_i[4:0]) : a_i >> b_i[4:0];
      F3_OR:   res_o = a_i | b_i;
      F3_AND:  res_o = a_i & b_i;
      default: res_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// RV32I execute stage: ALU, branch/jump resolution, sticky ECALL/EBREAK halt,
// retired-instruction counter and the EX/MEM pipeline register.
module execute
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ID_EX_pc,
  input  logic [31:0] ID_EX_inst,
  input  logic [31:0] ID_EX_rs1,
  input  logic [31:0] ID_EX_rs2,
  input  logic [4:0]  ID_EX_rd,
  input  logic [31:0] ID_EX_imm,
  input  logic        ID_EX_is_jalr,
  input  logic        ID_EX_is_jal,
  input  logic        ID_EX_is_sys,
  input  logic        ID_EX_is_branch,
  output logic [31:0] ID_EX_alu,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [31:0] EX_MEM_pc,
  output logic [31:0] EX_MEM_inst,
  output logic [31:0] EX_MEM_alu,
  output logic [31:0] EX_MEM_rs2,
  output logic [4:0]  EX_MEM_rd,
  output logic        halted,
  output logic [31:0] exec_count
);

  halt_state_e state_q;
  logic [31:0] pc_q, inst_q, alu_q, rs2_q, cnt_q;
  logic [4:0]  rd_q;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        valid, cond, is_halt;
  logic [31:0] alu_b, alu_res, pc_imm;
  logic [2:0]  alu_f3;
  logic        alu_alt;

  assign opc    = ID_EX_inst[6:0];
  assign f3     = ID_EX_inst[14:12];
  assign valid  = (ID_EX_inst != 32'h0) && (state_q == RUN);
  assign pc_imm = ID_EX_pc + ID_EX_imm;

  // Only OP uses inst[30] for SUB; OP-IMM uses it solely to pick SRAI over SRLI.
  assign alu_b   = (opc == RCC) ? ID_EX_rs2 : ID_EX_imm;
  assign alu_f3  = (opc == RCC || opc == MCC) ? f3 : F3_ADD;
  assign alu_alt = ID_EX_inst[30] && (opc == RCC || (opc == MCC && f3 == F3_SR));

  alu u_alu (
    .a_i      (ID_EX_rs1),
    .b_i      (alu_b),
    .funct3_i (alu_f3),
    .alt_i    (alu_alt),
    .res_o    (alu_res)
  );

  always_comb begin
    ID_EX_alu = 32'h0;
    unique case (opc)
      LUI:                ID_EX_alu = ID_EX_imm;
      AUIPC:              ID_EX_alu = pc_imm;
      JAL, JALR:          ID_EX_alu = ID_EX_pc + 32'd4;
      LCC, SCC, MCC, RCC: ID_EX_alu = alu_res;
      default:            ID_EX_alu = 32'h0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    unique case (f3)
      F3_BEQ:  cond = ID_EX_rs1 == ID_EX_rs2;
      F3_BNE:  cond = ID_EX_rs1 != ID_EX_rs2;
      F3_BLT:  cond = $signed(ID_EX_rs1) <  $signed(ID_EX_rs2);
      F3_BGE:  cond = $signed(ID_EX_rs1) >= $signed(ID_EX_rs2);
      F3_BLTU: cond = ID_EX_rs1 <  ID_EX_rs2;
      F3_BGEU: cond = ID_EX_rs1 >= ID_EX_rs2;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken  = !RST && valid &&
                         (ID_EX_is_jal || ID_EX_is_jalr || (ID_EX_is_branch && cond));
  assign branch_target = ID_EX_is_jalr ? ((ID_EX_rs1 + ID_EX_imm) & ~32'h1) : pc_imm;
  assign is_halt       = valid && ID_EX_is_sys && (ID_EX_inst == ECALL || ID_EX_inst == EBREAK);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      alu_q   <= 32'h0;
      rs2_q   <= 32'h0;
      rd_q    <= 5'h0;
      cnt_q   <= 32'h0;
    end else begin
      unique case (state_q)
        RUN:     if (is_halt) state_q <= HALT;
        HALT:    state_q <= HALT;
        default: state_q <= RUN;
      endcase
      pc_q   <= ID_EX_pc;
      rs2_q  <= ID_EX_rs2;
      inst_q <= valid ? ID_EX_inst : 32'h0;
      alu_q  <= valid ? ID_EX_alu  : 32'h0;
      rd_q   <= valid ? ID_EX_rd   : 5'h0;
      if (valid) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign halted      = (state_q == HALT);
  assign exec_count  = cnt_q;
  assign EX_MEM_pc   = pc_q;
  assign EX_MEM_inst = inst_q;
  assign EX_MEM_alu  = alu_q;
  assign EX_MEM_rs2  = rs2_q;
  assign EX_MEM_rd   = rd_q;

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage with hand-computed expectations.
module tb_execute;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ID_EX_pc, ID_EX_inst, ID_EX_rs1, ID_EX_rs2, ID_EX_imm;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_is_jalr, ID_EX_is_jal, ID_EX_is_sys, ID_EX_is_branch;
  logic [31:0] ID_EX_alu, branch_target;
  logic        branch_taken, halted;
  logic [31:0] EX_MEM_pc, EX_MEM_inst, EX_MEM_alu, EX_MEM_rs2, exec_count;
  logic [4:0]  EX_MEM_rd;

  int n_chk = 0;
  int n_err = 0;

  execute #(.RESET_PC(RPC)) dut (
    .CLK(CLK), .RST(RST),
    .ID_EX_pc(ID_EX_pc), .ID_EX_inst(ID_EX_inst), .ID_EX_rs1(ID_EX_rs1),
    .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd), .ID_EX_imm(ID_EX_imm),
    .ID_EX_is_jalr(ID_EX_is_jalr), .ID_EX_is_jal(ID_EX_is_jal),
    .ID_EX_is_sys(ID_EX_is_sys), .ID_EX_is_branch(ID_EX_is_branch),
    .ID_EX_alu(ID_EX_alu), .branch_taken(branch_taken), .branch_target(branch_target),
    .EX_MEM_pc(EX_MEM_pc), .EX_MEM_inst(EX_MEM_inst), .EX_MEM_alu(EX_MEM_alu),
    .EX_MEM_rs2(EX_MEM_rs2), .EX_MEM_rd(EX_MEM_rd),
    .halted(halted), .exec_count(exec_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, inst, rs1, rs2, imm, input logic [4:0] rd,
                       input logic jalr, jal, sys, br);
    ID_EX_pc = pc; ID_EX_inst = inst; ID_EX_rs1 = rs1; ID_EX_rs2 = rs2;
    ID_EX_imm = imm; ID_EX_rd = rd;
    ID_EX_is_jalr = jalr; ID_EX_is_jal = jal; ID_EX_is_sys = sys; ID_EX_is_branch = br;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_pc",    EX_MEM_pc, RPC);
    check("rst_inst",  EX_MEM_inst, 32'h0);
    check("rst_halt",  {31'h0, halted}, 32'h0);
    check("rst_cnt",   exec_count, 32'h0);
    RST = 1'b0;

    // ADD x3,x1,x2
    drive(32'h200, 32'h002081B3, 32'd5, 32'd7, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("add_alu", ID_EX_alu, 32'd12);
    check("add_bt",  {31'h0, branch_taken}, 32'h0);
    tick();
    check("add_rd",   {27'h0, EX_MEM_rd}, 32'd3);
    check("add_exalu", EX_MEM_alu, 32'd12);
    check("add_rs2",  EX_MEM_rs2, 32'd7);
    check("add_pc",   EX_MEM_pc, 32'h200);
    check("add_cnt",  exec_count, 32'd1);

    drive(32'h204, 32'h402081B3, 32'd5, 32'd7, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sub_alu", ID_EX_alu, 32'hFFFF_FFFE);
    tick();

    // SRAI x3,x1,4
    drive(32'h208, 32'h4040D193, 32'h8000_0000, 32'h0, 32'h0000_0404, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("srai_alu", ID_EX_alu, 32'hF800_0000);
    tick();
    drive(32'h20C, 32'h0020B1B3, 32'd1, 32'hFFFF_FFFF, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sltu_alu", ID_EX_alu, 32'd1);
    tick();
    drive(32'h210, 32'h0020A1B3, 32'd1, 32'hFFFF_FFFF, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("slt_alu", ID_EX_alu, 32'd0);
    tick();

    // BLT / BLTU with rs1=-1, rs2=0
    drive(32'h100, 32'h0220C063, 32'hFFFF_FFFF, 32'h0, 32'h20, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("blt_bt",  {31'h0, branch_taken}, 32'h1);
    check("blt_tgt", branch_target, 32'h120);
    tick();
    drive(32'h100, 32'h0220E063, 32'hFFFF_FFFF, 32'h0, 32'h20, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bltu_bt",  {31'h0, branch_taken}, 32'h0);
    check("bltu_tgt", branch_target, 32'h120);
    tick();

    // JALR x1,0(x5)
    drive(32'h40, 32'h000280E7, 32'h203, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("jalr_bt",  {31'h0, branch_taken}, 32'h1);
    check("jalr_tgt", branch_target, 32'h202);
    check("jalr_alu", ID_EX_alu, 32'h44);
    tick();
    check("jalr_cnt", exec_count, 32'd8);

    // bubble with a stray jump flag
    drive(32'h44, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    check("bub_bt", {31'h0, branch_taken}, 32'h0);
    tick();
    check("bub_inst", EX_MEM_inst, 32'h0);
    check("bub_rd",   {27'h0, EX_MEM_rd}, 32'h0);
    check("bub_cnt",  exec_count, 32'd8);

    // CSRRW: passes through, alu 0, no halt
    drive(32'h48, 32'h34011073, 32'h55, 32'h0, 32'h340, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("csr_inst", EX_MEM_inst, 32'h34011073);
    check("csr_alu",  EX_MEM_alu, 32'h0);
    check("csr_halt", {31'h0, halted}, 32'h0);

    drive(32'h4C, 32'h0010_0073, 32'h0, 32'h0, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("ebk_halt", {31'h0, halted}, 32'h1);
    check("ebk_inst", EX_MEM_inst, 32'h0010_0073);
    check("ebk_alu",  EX_MEM_alu, 32'h0);
    check("ebk_cnt",  exec_count, 32'd10);

    // ADD stream (flagged as a jump) after halt
    for (int i = 0; i < 3; i++) begin
      drive(32'h50 + 32'(4 * i), 32'h002081B3, 32'd5, 32'd7, 32'h8, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      check("hlt_bt", {31'h0, branch_taken}, 32'h0);
      tick();
      check("hlt_inst", EX_MEM_inst, 32'h0);
      check("hlt_cnt",  exec_count, 32'd10);
    end

    // asynchronous reset mid-cycle with a JAL presented
    #2;
    RST = 1'b1;
    #1;
    check("arst_halt", {31'h0, halted}, 32'h0);
    check("arst_cnt",  exec_count, 32'h0);
    check("arst_pc",   EX_MEM_pc, RPC);
    check("arst_alu",  EX_MEM_alu, 32'h0);
    check("arst_rs2",  EX_MEM_rs2, 32'h0);
    check("arst_bt",   {31'h0, branch_taken}, 32'h0);
    tick();
    RST = 1'b0;
    tick();
    check("post_cnt", exec_count, 32'd1);
    check("post_halt", {31'h0, halted}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
